// File: rtl/execute_pipe.sv
// Y86 execute stage: ALU/valE generation, condition evaluation, condition codes and the E/M register.
// Optional orq/shlq ALU functions are enabled by defining EXEC_EXT_ALU_EN.
module execute_pipe #(
  parameter int WIDTH = 64,
  parameter int STEP  = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E_valid,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             M_stall,
  input  logic             M_bubble,
  input  logic             cc_block,
  output logic [WIDTH-1:0] e_valE,
  output logic             e_cnd,
  output logic [3:0]       e_dstE,
  output logic             M_valid,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic [2:0]       cc
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] alu_res;
  logic             alu_ok;
  logic             alu_of;
  logic             sign_a;
  logic             sign_b;
  logic             sign_r;
  logic             cc_upd;
  logic [2:0]       cc_next;
  logic             zf;
  logic             sf;
  logic             of;
  logic             cond_raw;

  assign sign_a = E_valA[WIDTH-1];
  assign sign_b = E_valB[WIDTH-1];
  assign sign_r = alu_res[WIDTH-1];

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    alu_of  = 1'b0;
    case (E_ifun)
      4'h0: begin
        alu_res = E_valB + E_valA;
        alu_of  = (sign_a == sign_b) && (sign_r != sign_a);
      end
      4'h1: begin
        alu_res = E_valB - E_valA;
        alu_of  = (sign_a != sign_b) && (sign_r != sign_b);
      end
      4'h2: alu_res = E_valA & E_valB;
      4'h3: alu_res = E_valA ^ E_valB;
`ifdef EXEC_EXT_ALU_EN
      4'h4: alu_res = E_valA | E_valB;
      4'h5: alu_res = E_valB << E_valA[SHW-1:0];
`endif
      default: alu_ok = 1'b0;
    endcase
  end

`ifndef EXEC_EXT_ALU_EN
  // Shift amount is only consumed by the extended ALU.
  logic [SHW-1:0] unused_shamt;
  assign unused_shamt = E_valA[SHW-1:0];
`endif

  always_comb begin
    e_valE = '0;
    case (E_icode)
      I_RRMOVQ:          e_valE = E_valA;
      I_IRMOVQ:          e_valE = E_valC;
      I_RMMOVQ, I_MRMOVQ: e_valE = E_valB + E_valC;
      I_OPQ:             e_valE = alu_res;
      I_CALL, I_PUSHQ:   e_valE = E_valB - STEP_W;
      I_RET, I_POPQ:     e_valE = E_valB + STEP_W;
      default:           e_valE = '0;
    endcase
  end

  // Conditions read the registered flags, so an OPq's result is visible to the next instruction.
  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  always_comb begin
    cond_raw = 1'b0;
    case (E_ifun)
      4'h0: cond_raw = 1'b1;
      4'h1: cond_raw = (sf ^ of) | zf;
      4'h2: cond_raw = sf ^ of;
      4'h3: cond_raw = zf;
      4'h4: cond_raw = !zf;
      4'h5: cond_raw = !(sf ^ of);
      4'h6: cond_raw = !(sf ^ of) && !zf;
      default: cond_raw = 1'b0;
    endcase
  end

  assign e_cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? cond_raw : 1'b0;
  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_cnd) ? R_NONE : E_dstE;

  assign cc_upd = E_valid && (E_icode == I_OPQ) && (E_stat == STAT_AOK) && alu_ok
                  && !cc_block && !M_stall && !M_bubble && !rst;
  assign cc_next = {(alu_res == '0), sign_r, alu_of};

  always_ff @(posedge clk) begin
    if (rst) begin
      cc <= 3'b100;
    end else if (cc_upd) begin
      cc <= cc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      M_valid <= 1'b0;
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else if (M_stall) begin
      M_valid <= M_valid;
    end else if (M_bubble || !E_valid) begin
      M_valid <= 1'b0;
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else begin
      M_valid <= 1'b1;
      M_stat  <= ((E_icode == I_OPQ) && !alu_ok) ? STAT_INS : E_stat;
      M_icode <= E_icode;
      M_cnd   <= e_cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: a 64-bit and a 32-bit instance share stimulus and are checked
// against a width-generic arithmetic reference model, followed by randomized traffic.
module tb_execute_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  stat;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] va;
  logic [63:0] vb;
  logic [63:0] vc;
  logic [3:0]  dste;
  logic [3:0]  dstm;
  logic        stall;
  logic        bubble;
  logic        ccb;

  logic [63:0] a_e_valE;
  logic        a_e_cnd;
  logic [3:0]  a_e_dstE;
  logic        a_M_valid;
  logic [2:0]  a_M_stat;
  logic [3:0]  a_M_icode;
  logic        a_M_cnd;
  logic [63:0] a_M_valE;
  logic [63:0] a_M_valA;
  logic [3:0]  a_M_dstE;
  logic [3:0]  a_M_dstM;
  logic [2:0]  a_cc;

  logic [31:0] b_e_valE;
  logic        b_e_cnd;
  logic [3:0]  b_e_dstE;
  logic        b_M_valid;
  logic [2:0]  b_M_stat;
  logic [3:0]  b_M_icode;
  logic        b_M_cnd;
  logic [31:0] b_M_valE;
  logic [31:0] b_M_valA;
  logic [3:0]  b_M_dstE;
  logic [3:0]  b_M_dstM;
  logic [2:0]  b_cc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_pipe #(.WIDTH(64), .STEP(8)) dut64 (
    .clk(clk), .rst(rst), .E_valid(valid), .E_stat(stat), .E_icode(icode), .E_ifun(ifun),
    .E_valA(va), .E_valB(vb), .E_valC(vc), .E_dstE(dste), .E_dstM(dstm),
    .M_stall(stall), .M_bubble(bubble), .cc_block(ccb),
    .e_valE(a_e_valE), .e_cnd(a_e_cnd), .e_dstE(a_e_dstE),
    .M_valid(a_M_valid), .M_stat(a_M_stat), .M_icode(a_M_icode), .M_cnd(a_M_cnd),
    .M_valE(a_M_valE), .M_valA(a_M_valA), .M_dstE(a_M_dstE), .M_dstM(a_M_dstM), .cc(a_cc)
  );

  execute_pipe #(.WIDTH(32), .STEP(8)) dut32 (
    .clk(clk), .rst(rst), .E_valid(valid), .E_stat(stat), .E_icode(icode), .E_ifun(ifun),
    .E_valA(va[31:0]), .E_valB(vb[31:0]), .E_valC(vc[31:0]), .E_dstE(dste), .E_dstM(dstm),
    .M_stall(stall), .M_bubble(bubble), .cc_block(ccb),
    .e_valE(b_e_valE), .e_cnd(b_e_cnd), .e_dstE(b_e_dstE),
    .M_valid(b_M_valid), .M_stat(b_M_stat), .M_icode(b_M_icode), .M_cnd(b_M_cnd),
    .M_valE(b_M_valE), .M_valA(b_M_valA), .M_dstE(b_M_dstE), .M_dstM(b_M_dstM), .cc(b_cc)
  );

  typedef struct {
    logic [63:0] valE;
    logic        cnd;
    logic [3:0]  dstE;
    logic        ok;
    logic [2:0]  ncc;
  } res_t;

  typedef struct {
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } mreg_t;

  mreg_t      exp_m[2];
  logic [2:0] exp_cc[2];

  function automatic int width_of(int k);
    return (k == 0) ? 64 : 32;
  endfunction

  function automatic logic [63:0] mask_of(int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Two's-complement value of a w-bit pattern, widened so sums cannot wrap.
  function automatic logic signed [66:0] sval(logic [63:0] x, int w);
    logic signed [66:0] s;
    s = $signed({3'b000, x});
    if (x[w-1]) s = s - (67'sd1 <<< w);
    return s;
  endfunction

  function automatic logic out_of_range(logic signed [66:0] v, int w);
    logic signed [66:0] hi;
    logic signed [66:0] lo;
    hi = (67'sd1 <<< (w - 1)) - 67'sd1;
    lo = -(67'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  function automatic res_t model(int w, logic [3:0] ic, logic [3:0] fn, logic [63:0] a_in,
                                 logic [63:0] b_in, logic [63:0] c_in, logic [2:0] ccv,
                                 logic [3:0] de);
    res_t r;
    logic [63:0] m, a, b, c, alu;
    logic ovf, zf, sf, of, lt;
    m = mask_of(w);
    a = a_in & m; b = b_in & m; c = c_in & m;
    alu = 64'd0; ovf = 1'b0; r.ok = 1'b1;
    case (fn)
      4'd0: begin alu = b + a; ovf = out_of_range(sval(b, w) + sval(a, w), w); end
      4'd1: begin alu = b - a; ovf = out_of_range(sval(b, w) - sval(a, w), w); end
      4'd2: alu = a & b;
      4'd3: alu = a ^ b;
`ifdef EXEC_EXT_ALU_EN
      4'd4: alu = a | b;
      4'd5: alu = b << int'(a % 64'(w));
`endif
      default: r.ok = 1'b0;
    endcase
    alu = alu & m;
    case (ic)
      4'd2: r.valE = a;
      4'd3: r.valE = c;
      4'd4, 4'd5: r.valE = b + c;
      4'd6: r.valE = alu;
      4'd8, 4'd10: r.valE = b - 64'd8;
      4'd9, 4'd11: r.valE = b + 64'd8;
      default: r.valE = 64'd0;
    endcase
    r.valE = r.valE & m;
    r.ncc = {alu == 64'd0, alu[w-1], ovf};
    zf = ccv[2]; sf = ccv[1]; of = ccv[0];
    lt = sf != of;
    r.cnd = 1'b0;
    if (ic == 4'd2 || ic == 4'd7) begin
      case (fn)
        4'd0: r.cnd = 1'b1;
        4'd1: r.cnd = lt || zf;
        4'd2: r.cnd = lt;
        4'd3: r.cnd = zf;
        4'd4: r.cnd = !zf;
        4'd5: r.cnd = !lt;
        4'd6: r.cnd = !lt && !zf;
        default: r.cnd = 1'b0;
      endcase
    end
    r.dstE = (ic == 4'd2 && !r.cnd) ? 4'hF : de;
    return r;
  endfunction

  function automatic mreg_t nop_regs();
    mreg_t z;
    z.valid = 1'b0; z.stat = 3'd1; z.icode = 4'd1; z.cnd = 1'b0;
    z.valE = 64'd0; z.valA = 64'd0; z.dstE = 4'hF; z.dstM = 4'hF;
    return z;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                       input logic [3:0] dm);
    rst = 1'b0; valid = 1'b1; stat = 3'd1; icode = ic; ifun = fn;
    va = a; vb = b; vc = c; dste = de; dstm = dm;
    stall = 1'b0; bubble = 1'b0; ccb = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, check E/M register and flags.
  task automatic step();
    res_t r[2];
    for (int k = 0; k < 2; k++)
      r[k] = model(width_of(k), icode, ifun, va, vb, vc, exp_cc[k], dste);
    #1;
    chk("e_valE64", a_e_valE, r[0].valE);
    chk("e_cnd64", 64'(a_e_cnd), 64'(r[0].cnd));
    chk("e_dstE64", 64'(a_e_dstE), 64'(r[0].dstE));
    chk("e_valE32", 64'(b_e_valE), r[1].valE);
    chk("e_cnd32", 64'(b_e_cnd), 64'(r[1].cnd));
    chk("e_dstE32", 64'(b_e_dstE), 64'(r[1].dstE));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        exp_m[k] = nop_regs();
        exp_cc[k] = 3'b100;
      end else if (!stall) begin
        if (bubble || !valid) begin
          exp_m[k] = nop_regs();
        end else begin
          exp_m[k].valid = 1'b1;
          exp_m[k].stat  = (icode == 4'd6 && !r[k].ok) ? 3'd4 : stat;
          exp_m[k].icode = icode;
          exp_m[k].cnd   = r[k].cnd;
          exp_m[k].valE  = r[k].valE;
          exp_m[k].valA  = va & mask_of(width_of(k));
          exp_m[k].dstE  = r[k].dstE;
          exp_m[k].dstM  = dstm;
        end
        if (valid && !bubble && !ccb && icode == 4'd6 && stat == 3'd1 && r[k].ok)
          exp_cc[k] = r[k].ncc;
      end
    end
    @(negedge clk);
    chk("M_valid64", 64'(a_M_valid), 64'(exp_m[0].valid));
    chk("M_stat64", 64'(a_M_stat), 64'(exp_m[0].stat));
    chk("M_icode64", 64'(a_M_icode), 64'(exp_m[0].icode));
    chk("M_cnd64", 64'(a_M_cnd), 64'(exp_m[0].cnd));
    chk("M_valE64", a_M_valE, exp_m[0].valE);
    chk("M_valA64", a_M_valA, exp_m[0].valA);
    chk("M_dstE64", 64'(a_M_dstE), 64'(exp_m[0].dstE));
    chk("M_dstM64", 64'(a_M_dstM), 64'(exp_m[0].dstM));
    chk("cc64", 64'(a_cc), 64'(exp_cc[0]));
    chk("M_valid32", 64'(b_M_valid), 64'(exp_m[1].valid));
    chk("M_stat32", 64'(b_M_stat), 64'(exp_m[1].stat));
    chk("M_icode32", 64'(b_M_icode), 64'(exp_m[1].icode));
    chk("M_cnd32", 64'(b_M_cnd), 64'(exp_m[1].cnd));
    chk("M_valE32", 64'(b_M_valE), exp_m[1].valE);
    chk("M_valA32", 64'(b_M_valA), exp_m[1].valA);
    chk("M_dstE32", 64'(b_M_dstE), 64'(exp_m[1].dstE));
    chk("M_dstM32", 64'(b_M_dstM), 64'(exp_m[1].dstM));
    chk("cc32", 64'(b_cc), 64'(exp_cc[1]));
  endtask

  function automatic logic [63:0] rand_val();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'h7FFF_FFFF_FFFF_FFFF;
      3: v = 64'h8000_0000_8000_0000;
      4: v = 64'($urandom_range(0, 40));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    logic [3:0] ic_tab [0:15];
    ic_tab = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd7, 4'd7, 4'd2, 4'd2,
               4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd10, 4'd11};

    drive(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_m[k] = nop_regs();
      exp_cc[k] = 3'b100;
    end
    chk("rst_M_valid", 64'(a_M_valid), 64'd0);
    chk("rst_M_icode", 64'(a_M_icode), 64'd1);
    chk("rst_M_dstE", 64'(a_M_dstE), 64'hF);
    chk("rst_cc", 64'(a_cc), 64'b100);

    // Signed overflow on add, then conditions from the new flags.
    drive(4'd6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd2, 4'hF);
    step();
    chk("addq_valE", a_M_valE, 64'h8000_0000_0000_0000);
    chk("addq_cc", 64'(a_cc), 64'b011);
    drive(4'd7, 4'd2, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    step();
    chk("jl_cnd", 64'(a_M_cnd), 64'd0);
    drive(4'd7, 4'd5, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    step();
    chk("jge_cnd", 64'(a_M_cnd), 64'd1);

    drive(4'd6, 4'd1, 64'd5, 64'd5, 64'd0, 4'd4, 4'hF);
    step();
    chk("subq_cc", 64'(a_cc), 64'b100);
    drive(4'd2, 4'd3, 64'h1234, 64'd0, 64'd0, 4'd3, 4'hF);
    step();
    chk("cmove_dstE", 64'(a_M_dstE), 64'd3);
    drive(4'd2, 4'd4, 64'h1234, 64'd0, 64'd0, 4'd3, 4'hF);
    step();
    chk("cmovne_dstE", 64'(a_M_dstE), 64'hF);

    drive(4'd10, 4'd0, 64'd0, 64'h100, 64'd0, 4'd4, 4'hF);
    step();
    chk("pushq_valE", a_M_valE, 64'hF8);
    drive(4'd11, 4'd0, 64'd0, 64'h100, 64'd0, 4'd4, 4'd7);
    step();
    chk("popq_valE", a_M_valE, 64'h108);
    chk("push_pop_cc", 64'(a_cc), 64'b100);

    // Stall twice, bubble, then a blocked flag update.
    drive(4'd3, 4'd0, 64'd0, 64'd0, 64'h55, 4'd1, 4'hF);
    step();
    drive(4'd6, 4'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 4'd1, 4'hF);
    stall = 1'b1;
    step();
    step();
    chk("stall_icode", 64'(a_M_icode), 64'd3);
    chk("stall_valE", a_M_valE, 64'h55);
    chk("stall_cc", 64'(a_cc), 64'b100);
    stall = 1'b0; bubble = 1'b1;
    step();
    chk("bubble_icode", 64'(a_M_icode), 64'd1);
    chk("bubble_dstE", 64'(a_M_dstE), 64'hF);
    chk("bubble_valid", 64'(a_M_valid), 64'd0);
    chk("bubble_cc", 64'(a_cc), 64'b100);
    drive(4'd6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd2, 4'hF);
    step();
    drive(4'd6, 4'd1, 64'd1, 64'd1, 64'd0, 4'd2, 4'hF);
    ccb = 1'b1;
    step();
    chk("ccblock_cc", 64'(a_cc), 64'b011);

    drive(4'd6, 4'd0, 64'd3, 64'd4, 64'd0, 4'd2, 4'd5);
    rst = 1'b1;
    step();
    chk("midrst_icode", 64'(a_M_icode), 64'd1);
    chk("midrst_dstM", 64'(a_M_dstM), 64'hF);
    chk("midrst_cc", 64'(a_cc), 64'b100);

    drive(4'd6, 4'd5, 64'd4, 64'd1, 64'd0, 4'd2, 4'hF);
    step();
`ifdef EXEC_EXT_ALU_EN
    chk("shlq_valE32", 64'(b_M_valE), 64'h10);
    chk("shlq_stat32", 64'(b_M_stat), 64'd1);
    chk("shlq_cc32", 64'(b_cc), 64'b000);
`else
    chk("shlq_valE32", 64'(b_M_valE), 64'd0);
    chk("shlq_stat32", 64'(b_M_stat), 64'd4);
    chk("shlq_cc32", 64'(b_cc), 64'b100);
`endif

    for (int n = 0; n < 600; n++) begin
      drive(ic_tab[$urandom_range(0, 15)], 4'($urandom_range(0, 7)),
            rand_val(), rand_val(), rand_val(), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
      rst    = ($urandom_range(0, 49) == 0);
      stall  = ($urandom_range(0, 7) == 0);
      bubble = ($urandom_range(0, 7) == 0);
      ccb    = ($urandom_range(0, 7) == 0);
      valid  = ($urandom_range(0, 7) != 0);
      stat   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 4)) : 3'd1;
      if (icode == 4'd6 && $urandom_range(0, 1) == 1) begin
        va = 64'($urandom_range(0, 3)) << 62;
        vb = va ^ (64'($urandom_range(0, 3)) << 62);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
